cxu_byteops_seq: RTL and testbench
==================================

CXU_BYTEOPS_SEQ -- requirements
Module: cxu_byteops_seq

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be a multiple of 8 in range 8..64.
REQ-002 Parameter NUM_STATES, default 4, number of per-state accumulator registers; SHALL be in range 1..8.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-007 cmd_payload_function_id  input  3  operation select.
REQ-008 cmd_payload_inputs_0  input  DATA_W  operand A.
REQ-009 cmd_payload_inputs_1  input  DATA_W  operand B.
REQ-010 cmd_payload_state_id  input  3  accumulator select.
REQ-011 cmd_payload_cxu_id  input  4  unused; no effect on behaviour.
REQ-012 cmd_payload_ready  input  1  sideband flag, captured on accept.
REQ-013 rsp_valid  output  1  response offered.
REQ-014 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a clk edge.
REQ-015 rsp_payload_outputs_0  output  DATA_W  registered result.
REQ-016 rsp_payload_ready  output  1  registered copy of cmd_payload_ready captured at accept.

Function
REQ-017 FSM states IDLE, BUSY, DONE; cmd_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in DONE.
REQ-018 IDLE + accept of function 6 -> BUSY; IDLE + accept of any other function -> DONE with result registered at the accepting edge, so rsp_valid rises one cycle after accept.
REQ-019 DONE + rsp_ready -> IDLE; DONE without rsp_ready SHALL hold rsp_payload_outputs_0 and rsp_payload_ready stable.
REQ-020 Function 0, byte sum: zero-extended sum of all 2*DATA_W/8 bytes of A and B, truncated modulo 2^DATA_W.
REQ-021 Function 1, byte swap: byte k of A to byte (DATA_W/8-1-k) of result.
REQ-022 Function 2, bit reverse: bit n of A to bit (DATA_W-1-n) of result.
REQ-023 Function 3, accumulate: state[sid] <= state[sid] + bytesum(A,B) mod 2^DATA_W; result = new value.
REQ-024 Function 4, read: result = state[sid]; no state change.
REQ-025 Function 5, clear: result = old state[sid]; state[sid] <= 0.
REQ-026 Function 6, multiply: unsigned shift-add over exactly DATA_W BUSY cycles, one multiplier bit per cycle; result = low DATA_W bits of A*B; BUSY -> DONE after DATA_W cycles, so rsp_valid rises DATA_W+1 cycles after accept.
REQ-027 Function 7: result 0, no state change, latency as REQ-018.
REQ-028 state_id >= NUM_STATES with functions 3-5: result 0, no accumulator modified.
REQ-029 Operands SHALL be captured at accept; input changes after accept SHALL not affect the result.
REQ-030 cmd_valid while not in IDLE SHALL be ignored (not accepted, no side effects).

Reset
REQ-031 reset asserted SHALL immediately, asynchronously force: FSM IDLE, rsp_valid 0, rsp_payload_outputs_0 0, rsp_payload_ready 0, all accumulators 0, multiply datapath cleared.
REQ-032 cmd_ready SHALL be 0 while reset is high and 1 on the first cycle after release.
REQ-033 reset during BUSY or DONE SHALL abandon the operation; no response SHALL ever be emitted for it.

Verification (DATA_W=32, NUM_STATES=4)
REQ-034 Byte sum: A=0x01020304, B=0x10203040 -> 0x000000AA, rsp_valid one cycle after accept.
REQ-035 Swap/reverse: function 1 A=0x11223344 -> 0x44332211; function 2 A=0x00000001 -> 0x80000000.
REQ-036 Multiply: A=0x00010003, B=0x00020005 -> 0x000B000F; rsp_valid exactly 33 cycles after accept; cmd_ready 0 throughout.
REQ-037 Accumulators: function 3 on sid 2 with A=0xFFFFFFFF, B=0, issued twice -> 0x000003FC then 0x000007F8; function 4 sid 2 -> 0x000007F8; function 5 sid 2 -> 0x000007F8; function 4 sid 2 -> 0; function 3 sid 5 -> 0, all accumulators unchanged.
REQ-038 Backpressure: rsp_ready held 0 for 5 cycles in DONE -> outputs stable, cmd_ready 0, no accept of a pending cmd_valid; accept occurs the cycle after the handshake.
REQ-039 Reset during multiply cycle 10 -> rsp_valid 0 immediately, accumulators 0, cmd_ready 1 after release, no stale response.

Source files
------------

// File: rtl/cxu_byteops_seq.sv
// Byte-oriented custom-function unit: byte sum/swap, bit reverse, per-state
// accumulators and an iterative shift-add multiplier behind a cmd/rsp handshake.
module cxu_byteops_seq #(
   parameter int DATA_W     = 32,
   parameter int NUM_STATES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_payload_function_id,
   input  logic [DATA_W-1:0] cmd_payload_inputs_0,
   input  logic [DATA_W-1:0] cmd_payload_inputs_1,
   input  logic [2:0]        cmd_payload_state_id,
   input  logic [3:0]        cmd_payload_cxu_id,
   input  logic              cmd_payload_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_payload_outputs_0,
   output logic              rsp_payload_ready
);

   localparam int NB = DATA_W / 8;
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              sb_q;
   logic [DATA_W-1:0] mcand_q, mplier_q, prod_q, prod_next;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] acc_rd [NUM_STATES];
   logic [DATA_W-1:0] sel_acc, bsum;
   logic              accept, sid_ok, mul_last;
   logic              unused_cxu;

   assign unused_cxu = ^cmd_payload_cxu_id;

   function automatic logic [DATA_W-1:0] byte_sum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] s;
      s = '0;
      for (int k = 0; k < NB; k++)
         s = s + DATA_W'(a[8*k +: 8]) + DATA_W'(b[8*k +: 8]);
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int k = 0; k < NB; k++)
         r[8*(NB-1-k) +: 8] = a[8*k +: 8];
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int n = 0; n < DATA_W; n++)
         r[DATA_W-1-n] = a[n];
      return r;
   endfunction

   assign accept    = cmd_valid && cmd_ready;
   assign sid_ok    = {1'b0, cmd_payload_state_id} < 4'(NUM_STATES);
   assign bsum      = byte_sum(cmd_payload_inputs_0, cmd_payload_inputs_1);
   assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_last  = (cnt_q == CW'(DATA_W - 1));

   always_comb begin
      sel_acc = '0;
      for (int i = 0; i < NUM_STATES; i++)
         if (cmd_payload_state_id == 3'(i))
            sel_acc = acc_rd[i];
   end

   // Out-of-range state ids read as zero for all accumulator functions
   always_comb begin
      res_d = '0;
      case (cmd_payload_function_id)
         3'd0:    res_d = bsum;
         3'd1:    res_d = byte_swap(cmd_payload_inputs_0);
         3'd2:    res_d = bit_rev(cmd_payload_inputs_0);
         3'd3:    res_d = sid_ok ? sel_acc + bsum : '0;
         3'd4,
         3'd5:    res_d = sid_ok ? sel_acc : '0;
         default: res_d = '0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = (cmd_payload_function_id == 3'd6) ? S_BUSY : S_DONE;
         S_BUSY: if (mul_last) state_d = S_DONE;
         S_DONE: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      cmd_ready = (state_q == S_IDLE) && !reset;
      rsp_valid = (state_q == S_DONE);
   end

   assign rsp_payload_outputs_0 = res_q;
   assign rsp_payload_ready     = sb_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q    <= '0;
         sb_q     <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (accept) begin
         res_q    <= res_d;
         sb_q     <= cmd_payload_ready;
         mcand_q  <= cmd_payload_inputs_0;
         mplier_q <= cmd_payload_inputs_1;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (state_q == S_BUSY) begin
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         prod_q   <= prod_next;
         cnt_q    <= cnt_q + CW'(1);
         if (mul_last) res_q <= prod_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STATES; gi++) begin : g_acc
         logic [DATA_W-1:0] acc_q;
         logic              hit;
         assign hit = accept && sid_ok && (cmd_payload_state_id == 3'(gi));
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               acc_q <= '0;
            else if (hit && cmd_payload_function_id == 3'd3)
               acc_q <= acc_q + bsum;
            else if (hit && cmd_payload_function_id == 3'd5)
               acc_q <= '0;
         end
         assign acc_rd[gi] = acc_q;
      end
   endgenerate

endmodule

// File: tb/tb_cxu_byteops_seq.sv
// Self-checking bench for cxu_byteops_seq: directed spec vectors plus random
// commands checked against an arithmetic reference model.
module tb_cxu_byteops_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  fn;
   logic [31:0] in0, in1;
   logic [2:0]  sid;
   logic [3:0]  cxu;
   logic        cmd_sb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_out;
   logic        rsp_sb;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] macc [4];

   always #5 clk = ~clk;

   cxu_byteops_seq #(.DATA_W(32), .NUM_STATES(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_function_id(fn), .cmd_payload_inputs_0(in0),
      .cmd_payload_inputs_1(in1), .cmd_payload_state_id(sid),
      .cmd_payload_cxu_id(cxu), .cmd_payload_ready(cmd_sb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_payload_outputs_0(rsp_out), .rsp_payload_ready(rsp_sb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_bsum(input logic [31:0] a, input logic [31:0] b);
      int s = 0;
      for (int k = 0; k < 4; k++) s += int'((a >> (8*k)) & 32'hFF) + int'((b >> (8*k)) & 32'hFF);
      return 32'(s);
   endfunction

   function automatic logic [31:0] m_swap(input logic [31:0] a);
      logic [31:0] r = 0;
      for (int k = 0; k < 4; k++) r |= ((a >> (8*k)) & 32'hFF) << (8*(3-k));
      return r;
   endfunction

   function automatic logic [31:0] m_rev(input logic [31:0] a);
      logic [31:0] r = 0;
      for (int n = 0; n < 32; n++) if (a[n]) r |= 32'h8000_0000 >> n;
      return r;
   endfunction

   // Reference model: returns the expected result and updates model accumulators
   task automatic m_exec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, output logic [31:0] exp);
      logic [63:0] p;
      exp = 0;
      case (f)
         3'd0: exp = m_bsum(a, b);
         3'd1: exp = m_swap(a);
         3'd2: exp = m_rev(a);
         3'd3: if (s < 4) begin macc[s] = macc[s] + m_bsum(a, b); exp = macc[s]; end
         3'd4: if (s < 4) exp = macc[s];
         3'd5: if (s < 4) begin exp = macc[s]; macc[s] = 0; end
         3'd6: begin p = 64'(a) * 64'(b); exp = p[31:0]; end
         default: exp = 0;
      endcase
   endtask

   task automatic drive_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] s, input logic sb);
      cmd_valid = 1'b1; fn = f; in0 = a; in1 = b; sid = s; cmd_sb = sb;
      cxu = 4'($urandom_range(0, 15));
   endtask

   task automatic scramble();
      cmd_valid = 1'b0; fn = 3'($urandom_range(0, 7)); in0 = $urandom; in1 = $urandom;
      sid = 3'($urandom_range(0, 7)); cmd_sb = 1'($urandom_range(0, 1));
   endtask

   // Issue one command, check latency, result, sideband, then consume the response
   task automatic run_cmd(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] s, input logic sb);
      logic [31:0] exp;
      int lat;
      bit busy_rdy;
      m_exec(f, a, b, s, exp);
      @(negedge clk);
      chk({tag, "_rdy"}, 64'(cmd_ready), 64'd1);
      drive_cmd(f, a, b, s, sb);
      @(posedge clk); #1;
      scramble();
      lat = 1; busy_rdy = 1'b0;
      while (!rsp_valid && lat < 100) begin
         if (cmd_ready) busy_rdy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), (f == 3'd6) ? 64'd33 : 64'd1);
      chk({tag, "_res"}, 64'(rsp_out), 64'(exp));
      chk({tag, "_sb"}, 64'(rsp_sb), 64'(sb));
      if (f == 3'd6) chk({tag, "_busy_rdy"}, 64'(busy_rdy), 64'd0);
      $display("txn %s fn=%0d a=%h b=%h sid=%0d -> %h lat=%0d", tag, f, a, b, s, rsp_out, lat);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp, held;
      logic        held_sb;
      bit          bad, stale;
      for (int i = 0; i < 4; i++) macc[i] = 0;
      reset = 1'b1; rsp_ready = 1'b0; cxu = 0;
      scramble();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_out", 64'(rsp_out), 64'd0);
      chk("rst_sb", 64'(rsp_sb), 64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

      run_cmd("bsum", 3'd0, 32'h0102_0304, 32'h1020_3040, 3'd0, 1'b1);
      chk("bsum_const", 64'(rsp_out), 64'h0000_00AA);
      run_cmd("swap", 3'd1, 32'h1122_3344, 32'h0, 3'd0, 1'b0);
      chk("swap_const", 64'(rsp_out), 64'h4433_2211);
      run_cmd("rev", 3'd2, 32'h0000_0001, 32'h0, 3'd0, 1'b1);
      chk("rev_const", 64'(rsp_out), 64'h8000_0000);
      run_cmd("mul", 3'd6, 32'h0001_0003, 32'h0002_0005, 3'd0, 1'b1);
      chk("mul_const", 64'(rsp_out), 64'h000B_000F);
      run_cmd("acc1", 3'd3, 32'hFFFF_FFFF, 32'h0, 3'd2, 1'b0);
      chk("acc1_const", 64'(rsp_out), 64'h3FC);
      run_cmd("acc2", 3'd3, 32'hFFFF_FFFF, 32'h0, 3'd2, 1'b0);
      chk("acc2_const", 64'(rsp_out), 64'h7F8);
      run_cmd("read", 3'd4, 32'h0, 32'h0, 3'd2, 1'b1);
      run_cmd("clr", 3'd5, 32'h0, 32'h0, 3'd2, 1'b0);
      chk("clr_const", 64'(rsp_out), 64'h7F8);
      run_cmd("read0", 3'd4, 32'h0, 32'h0, 3'd2, 1'b1);
      run_cmd("acc_a", 3'd3, 32'h0000_0101, 32'h0, 3'd1, 1'b0);
      run_cmd("sid5", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b1);
      for (int i = 0; i < 4; i++) run_cmd("rd_all", 3'd4, 32'h0, 32'h0, 3'(i), 1'b0);
      run_cmd("fn7", 3'd7, $urandom, $urandom, 3'd1, 1'b1);

      // Backpressure: response held 5 cycles with a competing command pending
      run_cmd("bp_pre", 3'd3, 32'h0000_0010, 32'h0, 3'd0, 1'b0);
      @(negedge clk);
      drive_cmd(3'd0, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 3'd0, 1'b1);
      @(posedge clk); #1;
      m_exec(3'd0, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 3'd0, exp);
      held = rsp_out; held_sb = rsp_sb;
      chk("bp_res", 64'(held), 64'(exp));
      drive_cmd(3'd3, 32'h0000_0020, 32'h0, 3'd0, 1'b0);
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (!rsp_valid || cmd_ready || rsp_out !== held || rsp_sb !== held_sb) bad = 1'b1;
      end
      chk("bp_stable", 64'(bad), 64'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_idle_rdy", 64'(cmd_ready), 64'd1);
      chk("bp_idle_vld", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      scramble();
      m_exec(3'd3, 32'h0000_0020, 32'h0, 3'd0, exp);
      chk("bp_acc_vld", 64'(rsp_valid), 64'd1);
      chk("bp_acc_res", 64'(rsp_out), 64'(exp));
      $display("txn bp_acc fn=3 sid=0 -> %h", rsp_out);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      for (int t = 0; t < 30; t++)
         run_cmd("rnd", 3'($urandom_range(0, 7)), $urandom, $urandom,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

      // Reset in the middle of a multiply
      run_cmd("pre_rst", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 3'd3, 1'b0);
      @(negedge clk);
      drive_cmd(3'd6, $urandom, $urandom, 3'd0, 1'b1);
      @(posedge clk); #1;
      scramble();
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst_vld", 64'(rsp_valid), 64'd0);
      chk("mrst_rdy", 64'(cmd_ready), 64'd0);
      chk("mrst_out", 64'(rsp_out), 64'd0);
      for (int i = 0; i < 4; i++) macc[i] = 0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk("mrst_rel_rdy", 64'(cmd_ready), 64'd1);
      stale = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (rsp_valid) stale = 1'b1;
      end
      chk("mrst_stale", 64'(stale), 64'd0);
      for (int i = 0; i < 4; i++) run_cmd("post_rst", 3'd4, 32'h0, 32'h0, 3'(i), 1'b0);
      run_cmd("post_mul", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
